// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one fixed-latency signed 32x32 multiplier among N_REQ requesters.
//   One operation is in flight at a time. A round-robin pick in IDLE latches
//   the winner's operands. ISSUE holds mul_start high until the multiplier
//   answers or the watchdog expires. DONE publishes the tagged response and
//   forces mul_start low for a cycle.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid[N_REQ]        per-requester request, held with operands until ack
//   req_mlier/req_mcand     flattened operands, slice i = [32*i+31:32*i]
//   req_ack[N_REQ]          one-hot capture pulse
//   rsp_valid               response pulse; rsp_id/rsp_prodt/rsp_err hold after it
//   busy                    high outside IDLE
//   mul_start/mlier/mcand   multiplier request side
//   mul_prodt/mul_valid     multiplier result side
//
// state | meaning
// IDLE  | waiting for a request; pick the winner and latch its operands
// ISSUE | mul_start high; wait for mul_valid or watchdog expiry
// DONE  | one-cycle response slot; mul_start low, watchdog cleared

module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 40
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_mlier,
    input  logic [32*N_REQ-1:0] req_mcand,
    output logic [N_REQ-1:0]    req_ack,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [63:0]         rsp_prodt,
    output logic                rsp_err,
    output logic                busy,
    output logic                mul_start,
    output logic [31:0]         mul_mlier,
    output logic [31:0]         mul_mcand,
    input  logic [63:0]         mul_prodt,
    input  logic                mul_valid
);

    // The count never has to represent more than TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  cur_id;
    logic [CNT_W-1:0] count;

    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [31:0]      win_mlier;
    logic [31:0]      win_mcand;
    logic             timeout_hit;

    // Round-robin search starting just after the last winner. The first hit
    // in the rotation wins, so the previous winner is checked last.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        win_mlier = '0;
        win_mcand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
                win_mlier = req_mlier[32*idx +: 32];
                win_mcand = req_mcand[32*idx +: 32];
            end
        end
    end

    assign timeout_hit = (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                busy      = 1'b1;
                if (mul_valid || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Response fields are loaded on the edge that enters DONE, so they are
    // already valid while rsp_valid is high and then hold until the next
    // response. A valid result takes priority over a coincident timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            last      <= ID_W'(N_REQ - 1);
            cur_id    <= '0;
            count     <= '0;
            req_ack   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prodt <= '0;
            rsp_err   <= 1'b0;
            mul_mlier <= '0;
            mul_mcand <= '0;
        end else begin
            req_ack   <= '0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        mul_mlier <= win_mlier;
                        mul_mcand <= win_mcand;
                        cur_id    <= win_id;
                        last      <= win_id;
                        req_ack   <= N_REQ'(1) << win_id;
                    end
                end
                ISSUE: begin
                    count <= count + 1'b1;
                    if (mul_valid) begin
                        rsp_prodt <= mul_prodt;
                        rsp_err   <= 1'b0;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        rsp_prodt <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    count <= '0;
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 40;

    logic                clock = 1'b0;
    logic                reset;
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_mlier;
    logic [32*N_REQ-1:0] req_mcand;
    logic [N_REQ-1:0]    req_ack;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_prodt;
    logic                rsp_err;
    logic                busy;
    logic                mul_start;
    logic [31:0]         mul_mlier;
    logic [31:0]         mul_mcand;
    logic [63:0]         mul_prodt;
    logic                mul_valid;

    mul_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_mlier (req_mlier),
        .req_mcand (req_mcand),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prodt (rsp_prodt),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_mlier (mul_mlier),
        .mul_mcand (mul_mcand),
        .mul_prodt (mul_prodt),
        .mul_valid (mul_valid)
    );

    always #5 clock = ~clock;

    // Multiplier model: answers after mul_lat cycles of mul_start high,
    // or never when mul_dead is set.
    int mul_lat  = 2;
    bit mul_dead = 1'b0;
    int mcnt     = 0;

    always @(posedge clock) begin
        if (!mul_start) mcnt <= 0;
        else            mcnt <= mcnt + 1;
    end

    assign mul_valid = mul_start && !mul_dead && (mcnt == mul_lat);
    assign mul_prodt = longint'($signed(mul_mlier)) * longint'($signed(mul_mcand));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7fff_ffff;
            2:       return 32'h0;
            3:       return 32'hffff_ffff;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Wait up to 'limit' negedges for req_ack; returns 1 if seen.
    task automatic wait_ack(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clock);
            if (req_ack != '0) got = 1'b1;
        end
    endtask

    task automatic wait_rsp(input int limit, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clock);
            cycles++;
            if (rsp_valid) got = 1'b1;
        end
    endtask

    task automatic do_single(input string name, input int id, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp_p);
        bit got;
        int cyc;
        logic [N_REQ-1:0] one;
        req_mlier[32*id +: 32] = a;
        req_mcand[32*id +: 32] = b;
        req_valid[id]          = 1'b1;
        wait_ack(20, got);
        one = '0;
        one[id] = 1'b1;
        check({name, "_ack"}, 64'(req_ack), 64'(one));
        req_valid[id] = 1'b0;
        wait_rsp(100, got, cyc);
        check({name, "_rsp_seen"}, 64'(got), 64'd1);
        check({name, "_rsp_id"}, 64'(rsp_id), 64'(id));
        check({name, "_prodt"}, rsp_prodt, exp_p);
        check({name, "_err"}, 64'(rsp_err), 64'd0);
    endtask

    typedef struct {
        string       name;
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vt[7];

    initial begin
        bit               got;
        int               cyc;
        int               acks[$];
        int               rsps[$];
        int               gaps[$];
        int               low_run;
        bit               seen_high;
        int               exp_order[5];
        logic [63:0]      rr_prod[N_REQ];

        req_mlier = '0;
        req_mcand = '0;
        do_reset();

        check("rst_ack",    64'(req_ack),   64'd0);
        check("rst_rspv",   64'(rsp_valid), 64'd0);
        check("rst_rspid",  64'(rsp_id),    64'd0);
        check("rst_prodt",  rsp_prodt,      64'd0);
        check("rst_err",    64'(rsp_err),   64'd0);
        check("rst_busy",   64'(busy),      64'd0);
        check("rst_start",  64'(mul_start), 64'd0);
        check("rst_mlier",  64'(mul_mlier), 64'd0);
        check("rst_mcand",  64'(mul_mcand), 64'd0);

        // Table-driven single operations
        vt[0] = '{"t_pos",   0, 32'd147483646, 32'd1,          64'd147483646};
        vt[1] = '{"t_negneg",2, -32'sd10,      -32'sd12345,    64'd123450};
        vt[2] = '{"t_negone",1, 32'd147483646, 32'hffff_ffff,  -64'sd147483646};
        vt[3] = '{"t_minmin",3, 32'h8000_0000, 32'h8000_0000,  64'h4000_0000_0000_0000};
        vt[4] = '{"t_minmax",0, 32'h8000_0000, 32'h7fff_ffff,  64'hc000_0000_8000_0000};
        vt[5] = '{"t_maxmax",2, 32'h7fff_ffff, 32'h7fff_ffff,  64'h3fff_ffff_0000_0001};
        vt[6] = '{"t_zero",  1, 32'd0,         32'hdead_beef,  64'd0};
        for (int i = 0; i < 7; i++) begin
            mul_lat = i % 4;
            do_single(vt[i].name, vt[i].id, vt[i].a, vt[i].b, vt[i].p);
        end

        // Result arriving on the last watchdog cycle is a normal response.
        mul_lat = TIMEOUT - 1;
        do_single("t_valid_at_timeout", 3, 32'd1000, 32'd3, 64'd3000);
        mul_lat = 2;

        // Round-robin: all requesters held from reset.
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            req_mlier[32*i +: 32] = 32'(i + 3);
            req_mcand[32*i +: 32] = 32'(-(i * 11 + 1));
            rr_prod[i] = ref_mul(32'(i + 3), 32'(-(i * 11 + 1)));
        end
        req_valid = '1;
        low_run   = 0;
        seen_high = 1'b0;
        for (int c = 0; c < 400 && rsps.size() < 5; c++) begin
            @(negedge clock);
            if (req_ack != '0) begin
                for (int i = 0; i < N_REQ; i++) if (req_ack[i]) acks.push_back(i);
                if (acks.size() == 5) req_valid = '0;
            end
            if (rsp_valid) begin
                rsps.push_back(int'(rsp_id));
                check("rr_prodt", rsp_prodt, rr_prod[rsp_id]);
            end
            if (!mul_start) low_run++;
            else begin
                if (seen_high && low_run > 0) gaps.push_back(low_run);
                low_run   = 0;
                seen_high = 1'b1;
            end
        end
        exp_order = '{0, 1, 2, 3, 0};
        check("rr_ack_count", 64'(acks.size()), 64'd5);
        check("rr_rsp_count", 64'(rsps.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < acks.size()) check($sformatf("rr_ack_%0d", k), 64'(acks[k]), 64'(exp_order[k]));
            if (k < rsps.size()) check($sformatf("rr_rspid_%0d", k), 64'(rsps[k]), 64'(exp_order[k]));
        end
        // mul_start is low through DONE and the following IDLE pick cycle.
        check("rr_gap_count", 64'(gaps.size()), 64'd4);
        foreach (gaps[k]) check($sformatf("rr_gap_%0d", k), 64'(gaps[k]), 64'd2);

        // Watchdog: multiplier never answers.
        mul_dead = 1'b1;
        req_mlier[32 +: 32] = 32'd5;
        req_mcand[32 +: 32] = 32'd7;
        req_valid[1] = 1'b1;
        wait_ack(20, got);
        check("wd_ack", 64'(req_ack), 64'b0010);
        check("wd_start_at_ack", 64'(mul_start), 64'd1);
        req_valid[1] = 1'b0;
        wait_rsp(100, got, cyc);
        check("wd_rsp_seen", 64'(got), 64'd1);
        check("wd_latency", 64'(cyc), 64'(TIMEOUT));
        check("wd_err", 64'(rsp_err), 64'd1);
        check("wd_prodt", rsp_prodt, 64'd0);
        check("wd_id", 64'(rsp_id), 64'd1);
        @(negedge clock);
        check("wd_err_hold", 64'(rsp_err), 64'd1);
        mul_dead = 1'b0;
        do_single("wd_next", 2, 32'd9, 32'hffff_fff9, -64'sd63);

        // Reset mid-operation
        mul_dead = 1'b1;
        req_mlier[31:0] = 32'd1;
        req_mcand[31:0] = 32'd34222;
        req_valid[0] = 1'b1;
        wait_ack(20, got);
        check("mr_ack", 64'(req_ack), 64'b0001);
        req_valid[0] = 1'b0;
        repeat (9) @(negedge clock);
        check("mr_start_before", 64'(mul_start), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mr_start", 64'(mul_start), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_rspv", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rsp_valid) got = 1'b1;
        end
        check("mr_no_rsp", 64'(got), 64'd0);
        mul_dead = 1'b0;
        do_single("mr_reissue", 0, 32'd1, 32'd34222, 64'd34222);

        // Randomized traffic against a reference model
        begin
            logic [N_REQ-1:0] exp_ack;
            int          mlast;
            bit          free, pfree, infl;
            int          win, infl_id, age, done_ops;
            logic [63:0] win_p, infl_p;
            bit          abort;

            do_reset();
            exp_ack  = '0;
            mlast    = N_REQ - 1;
            free     = 1'b1;
            pfree    = 1'b0;
            infl     = 1'b0;
            win      = 0;
            win_p    = '0;
            infl_id  = 0;
            infl_p   = '0;
            age      = 0;
            done_ops = 0;
            abort    = 1'b0;
            for (int c = 0; c < 20000 && done_ops < 150 && !abort; c++) begin
                @(negedge clock);
                if (exp_ack != '0 || req_ack != '0)
                    check("rand_ack", 64'(req_ack), 64'(exp_ack));
                if (exp_ack != '0) begin
                    infl          = 1'b1;
                    infl_id       = win;
                    infl_p        = win_p;
                    age           = 0;
                    req_valid[win] = 1'b0;
                end
                if (rsp_valid) begin
                    check("rand_rsp_expected", 64'(infl), 64'd1);
                    check("rand_rsp_id", 64'(rsp_id), 64'(infl_id));
                    check("rand_rsp_prodt", rsp_prodt, infl_p);
                    check("rand_rsp_err", 64'(rsp_err), 64'd0);
                    infl = 1'b0;
                    done_ops++;
                end
                if (pfree) begin
                    free  = 1'b1;
                    pfree = 1'b0;
                end
                if (rsp_valid) pfree = 1'b1;
                if (infl) begin
                    age++;
                    if (age > 60) begin
                        check("rand_rsp_timeout", 64'(age), 64'd60);
                        abort = 1'b1;
                    end
                end
                for (int i = 0; i < N_REQ; i++) begin
                    if (!req_valid[i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            req_mlier[32*i +: 32] = rnd_op();
                            req_mcand[32*i +: 32] = rnd_op();
                            req_valid[i] = 1'b1;
                        end
                    end else if ($urandom_range(0, 15) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
                if (free) mul_lat = $urandom_range(0, 6);
                exp_ack = '0;
                if (free && req_valid != '0) begin
                    for (int k = 1; k <= N_REQ; k++) begin
                        int idx;
                        idx = (mlast + k) % N_REQ;
                        if (exp_ack == '0 && req_valid[idx]) begin
                            exp_ack[idx] = 1'b1;
                            win = idx;
                        end
                    end
                    win_p = ref_mul(req_mlier[32*win +: 32], req_mcand[32*win +: 32]);
                    mlast = win;
                    free  = 1'b0;
                end
            end
            check("rand_ops_done", 64'(done_ops), 64'd150);
            req_valid = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
